// File: rtl/slc3_mem_arbiter.sv
// slc3_mem_arbiter
//   Shares one synchronous block RAM between the SLC-3 CPU memory interface
//   (port A) and the debug/program loader (port B). Each requester raises req
//   with its fields and waits for a one-cycle done pulse. The arbiter owns all
//   BRAM wait-state sequencing. Only one access is in flight at a time, and
//   grants alternate round-robin under contention.
//
// Ports
//   Clk, Reset            : rising-edge clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata, a_done : CPU request channel and completion pulse
//   b_req/b_we/b_addr/b_wdata, b_done : loader request channel and completion pulse
//   rdata                 : registered read data, valid from done until the next read completes
//   busy                  : high whenever an access is being sequenced
//   bram_en/bram_we/bram_addr/bram_din/bram_dout : BRAM port
module slc3_mem_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned READ_LAT = 2     // 1..7
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_done,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              owner;        // 0 = port A, 1 = port B
    logic              last_grant;   // 0 = port A, 1 = port B
    logic [2:0]        wait_cnt;
    logic              grant_b;
    logic              start;

    // B wins when it is the only requester, or when both request and A was
    // the most recent grant.
    assign grant_b = b_req && (!a_req || !last_grant);
    assign start   = (state == IDLE) && (a_req || b_req);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        a_done    = 1'b0;
        b_done    = 1'b0;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                bram_en   = 1'b1;
                bram_we   = lat_we;
                bram_addr = lat_addr;
                bram_din  = lat_wdata;
                state_nx  = lat_we ? DONE : WAIT;
            end
            WAIT: begin
                busy      = 1'b1;
                bram_en   = 1'b1;
                bram_addr = lat_addr;
                if (wait_cnt == 3'd1) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                a_done   = !owner;
                b_done   = owner;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            rdata      <= '0;
        end else begin
            if (start) begin
                owner      <= grant_b;
                last_grant <= grant_b;
                lat_addr   <= grant_b ? b_addr  : a_addr;
                lat_wdata  <= grant_b ? b_wdata : a_wdata;
                lat_we     <= grant_b ? b_we    : a_we;
            end
            if (state == ISSUE) begin
                wait_cnt <= 3'(READ_LAT);
            end
            // The counter reaches 1 in the last WAIT cycle, which is when
            // bram_dout carries the word addressed in ISSUE.
            if (state == WAIT) begin
                wait_cnt <= wait_cnt - 3'd1;
                if (wait_cnt == 3'd1) begin
                    rdata <= bram_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// tb_slc3_mem_arbiter
//   Directed scenarios followed by randomized two-port traffic. A cycle-stamped
//   transaction model predicts grant order, BRAM activity, done timing and
//   rdata. A behavioural BRAM with READ_LAT pipeline stages sits on the RAM port.
module tb_slc3_mem_arbiter;

    localparam int READ_LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_done, b_done, busy, bram_en, bram_we;
    logic [15:0] rdata, bram_addr, bram_din, bram_dout;

    slc3_mem_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .READ_LAT (READ_LAT)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_done    (a_done),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_done    (b_done),
        .rdata     (rdata),
        .busy      (busy),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] init_val(input int i);
        case (i)
            3:       return 16'h00FF;
            16:      return 16'h1234;
            48:      return 16'h1111;
            default: return 16'(i * 257) ^ 16'h5A5A;
        endcase
    endfunction

    // Behavioural BRAM: array read at the address edge, then READ_LAT-1
    // further register stages before bram_dout.
    logic [15:0] mem  [0:255];
    logic [15:0] pipe [0:7];
    logic        mem_loaded = 1'b0;

    always @(posedge Clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else if (bram_en && bram_we) begin
            mem[bram_addr[7:0]] <= bram_din;
        end
        pipe[0] <= mem[bram_addr[7:0]];
        for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign bram_dout = pipe[READ_LAT-1];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: one access described by its grant cycle arithmetic.
    logic [15:0] shadow [0:255];
    int          m_issue, m_done, m_free;
    logic        m_owner, m_we, m_last;
    logic [15:0] m_addr, m_wdata, m_rval, m_rdata;
    bit          a_done_now, b_done_now;
    bit          a_pend, b_pend;

    // Called just after a rising edge; checks this cycle at the falling edge,
    // applies the arbitration decision taken at the end of the cycle, and
    // returns just after the next rising edge.
    task automatic tick();
        bit act, en, iss;
        @(negedge Clk);
        act = (cyc >= m_issue) && (cyc <= m_done);
        en  = (cyc >= m_issue) && (cyc < m_done);
        iss = (cyc == m_issue);
        if (cyc == m_done && !m_we) m_rdata = m_rval;
        a_done_now = (cyc == m_done) && !m_owner;
        b_done_now = (cyc == m_done) && m_owner;
        check("busy", busy, act);
        check("bram_en", bram_en, en);
        check("bram_we", bram_we, iss && m_we);
        if (en)  check("bram_addr", bram_addr, m_addr);
        if (iss) check("bram_din", bram_din, m_wdata);
        check("a_done", a_done, a_done_now);
        check("b_done", b_done, b_done_now);
        check("done_excl", a_done & b_done, 1'b0);
        check("rdata", rdata, m_rdata);
        if (cyc >= m_free && (a_req || b_req)) begin
            m_owner = b_req && (!a_req || !m_last);
            m_last  = m_owner;
            m_we    = m_owner ? b_we    : a_we;
            m_addr  = m_owner ? b_addr  : a_addr;
            m_wdata = m_owner ? b_wdata : a_wdata;
            m_issue = cyc + 1;
            m_done  = cyc + (m_we ? 2 : READ_LAT + 2);
            m_free  = m_done + 1;
            if (m_we) shadow[m_addr[7:0]] = m_wdata;
            else      m_rval = shadow[m_addr[7:0]];
        end
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_done(input bit port_b);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(port_b ? b_done_now : a_done_now) && n < 40);
        check("done_seen", port_b ? b_done_now : a_done_now, 1'b1);
    endtask

    task automatic agent_drive();
        if (a_done_now) begin a_pend = 0; a_req = 1'b0; end
        if (!a_pend) begin
            if ($urandom_range(3) == 0) begin
                a_pend = 1; a_req = 1'b1;
                a_we    = 1'($urandom_range(1));
                a_addr  = 16'($urandom_range(15));
                a_wdata = 16'($urandom);
            end
        end else if (!m_owner && cyc >= m_issue && cyc <= m_done && $urandom_range(7) == 0) begin
            a_we    = 1'($urandom_range(1));
            a_addr  = 16'($urandom_range(15));
            a_wdata = 16'($urandom);
            if ($urandom_range(1) == 0) a_req = 1'b0;
        end
        if (b_done_now) begin b_pend = 0; b_req = 1'b0; end
        if (!b_pend) begin
            if ($urandom_range(3) == 0) begin
                b_pend = 1; b_req = 1'b1;
                b_we    = 1'($urandom_range(1));
                b_addr  = 16'($urandom_range(15));
                b_wdata = 16'($urandom);
            end
        end else if (m_owner && cyc >= m_issue && cyc <= m_done && $urandom_range(7) == 0) begin
            b_we    = 1'($urandom_range(1));
            b_addr  = 16'($urandom_range(15));
            b_wdata = 16'($urandom);
            if ($urandom_range(1) == 0) b_req = 1'b0;
        end
    endtask

    initial begin
        int   start;
        int   ndone;
        int   guard;
        logic prev_owner;

        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        Reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        m_issue = -10; m_done = -10; m_free = 0; m_last = 1'b1;
        m_owner = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rval = '0; m_rdata = '0;
        a_pend = 0; b_pend = 0; a_done_now = 0; b_done_now = 0;

        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy", busy, 1'b0);
        check("rst_en", bram_en, 1'b0);
        check("rst_we", bram_we, 1'b0);
        check("rst_addr", bram_addr, 16'h0);
        check("rst_din", bram_din, 16'h0);
        check("rst_adone", a_done, 1'b0);
        check("rst_bdone", b_done, 1'b0);
        check("rst_rdata", rdata, 16'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        cyc   = 0;

        // Single A read
        start = cyc;
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
        run_until_done(0);
        a_req = 1'b0;
        check("a_rd_lat", cyc - 1 - start, READ_LAT + 2);
        check("a_rd_data", rdata, 16'h1234);

        // B write then A read-back
        start = cyc;
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0020; b_wdata = 16'hBEEF;
        run_until_done(1);
        b_req = 1'b0; b_we = 1'b0;
        check("b_wr_lat", cyc - 1 - start, 2);
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0020;
        run_until_done(0);
        a_req = 1'b0;
        check("a_rd_back", rdata, 16'hBEEF);

        // rdata untouched by a write, then updated by B read
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0030;
        run_until_done(0);
        check("rd_1111", rdata, 16'h1111);
        a_we = 1'b1; a_addr = 16'h0040; a_wdata = 16'h2222;
        run_until_done(0);
        a_req = 1'b0; a_we = 1'b0;
        check("wr_keeps_rdata", rdata, 16'h1111);
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0020;
        run_until_done(1);
        b_req = 1'b0;
        check("b_rd_data", rdata, 16'hBEEF);

        // Fields latched at grant: address change during WAIT ignored
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0003;
        tick();
        tick();
        a_addr = 16'h0004;
        run_until_done(0);
        a_req = 1'b0;
        check("latched_addr", rdata, 16'h00FF);

        // Continuous contention: grants must alternate
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0005;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0006;
        ndone = 0; guard = 0; prev_owner = 1'b0;
        while (ndone < 6 && guard < 100) begin
            tick();
            guard++;
            if (a_done_now || b_done_now) begin
                if (ndone > 0) check("alternate", b_done_now, !prev_owner);
                prev_owner = b_done_now;
                ndone++;
                if (a_done_now) a_addr = 16'($urandom_range(15));
                else            b_addr = 16'($urandom_range(15));
            end
        end
        check("contention_dones", ndone, 6);
        a_req = 1'b0; b_req = 1'b0;
        repeat (12) tick();

        // Reset during WAIT of an A read, with B also pending
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
        tick();
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0030;
        tick();
        #2;
        Reset = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_en", bram_en, 1'b0);
        check("arst_addr", bram_addr, 16'h0);
        check("arst_adone", a_done, 1'b0);
        check("arst_rdata", rdata, 16'h0);
        m_issue = -10; m_done = -10; m_rdata = '0; m_last = 1'b1;
        a_done_now = 0; b_done_now = 0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        cyc++;
        m_free = cyc;
        run_until_done(0);
        a_req = 1'b0;
        check("post_rst_a", rdata, 16'h1234);
        run_until_done(1);
        b_req = 1'b0;
        check("post_rst_b", rdata, 16'h1111);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            agent_drive();
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
